// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Pipeline hazard detection, operand forwarding select and memory-stall control
// for a five-stage in-order pipeline.
//
// Parameters
//   TIMEOUT : number of memory-stall cycles tolerated before mem_err is raised
//   CNT_W   : width of the stall_cycles / flush_count performance counters
//
// Ports
//   clk, rst_n               : clock (rising edge), asynchronous active-low reset
//   id_src1, id_src2         : source registers of the instruction in ID
//   id_two_src               : ID instruction actually reads id_src2
//   fwd_en                   : forwarding enabled
//   exe_src1, exe_src2       : source registers held in the ID/EX register
//   exe_Dest, exe_WB_EN      : destination / write-back enable of the EX instr
//   exe_MEM_R_EN             : EX instruction is a load
//   exe_B                    : EX instruction is a taken branch
//   mem_Dest, mem_WB_EN      : destination / write-back enable of the MEM instr
//   mem_req, mem_ready       : load/store in MEM, memory has completed it
//   wb_Dest, wb_WB_EN        : destination / write-back enable of the WB instr
//   freeze                   : hold PC and IF/ID
//   flush                    : flush IF/ID and ID/EX (bubble or branch kill)
//   freeze_all               : hold every pipeline register (memory stall)
//   sel_src1, sel_src2       : operand select 00 regfile, 01 MEM, 10 WB
//   mem_err                  : sticky memory timeout flag
//   stall_cycles             : saturating count of cycles with freeze=1
//   flush_count              : saturating count of branch flushes
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             fwd_en,
  input  logic [3:0]       exe_src1,
  input  logic [3:0]       exe_src2,
  input  logic [3:0]       exe_Dest,
  input  logic             exe_WB_EN,
  input  logic             exe_MEM_R_EN,
  input  logic             exe_B,
  input  logic [3:0]       mem_Dest,
  input  logic             mem_WB_EN,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [3:0]       wb_Dest,
  input  logic             wb_WB_EN,
  output logic             freeze,
  output logic             flush,
  output logic             freeze_all,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // Last wait-counter value that is still tolerated; the cycle whose increment
  // lands on it is the TIMEOUT-th stalled cycle (the RUN entry cycle counts).
  localparam logic [8:0] WAIT_LAST = 9'(TIMEOUT - 1);

  // A producer stage matches a consumer source register.
  function automatic logic reg_hit(input logic en, input logic [3:0] dest,
                                   input logic [3:0] src);
    return en & (dest == src);
  endfunction

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [7:0]       wait_cnt_r, wait_cnt_nxt_s;
  logic [8:0]       wait_inc_s;
  logic             mem_err_r, err_set_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  logic hit_exe1_s, hit_exe2_s, hit_mem1_s, hit_mem2_s;
  logic hazard_s;
  logic stall_s;
  logic freeze_s, flush_s;
  logic [1:0] sel1_s, sel2_s;

  // Hazard detection against the EX and MEM stage destinations.
  always_comb begin
    hit_exe1_s = reg_hit(exe_WB_EN, exe_Dest, id_src1);
    hit_exe2_s = id_two_src & reg_hit(exe_WB_EN, exe_Dest, id_src2);
    hit_mem1_s = reg_hit(mem_WB_EN, mem_Dest, id_src1);
    hit_mem2_s = id_two_src & reg_hit(mem_WB_EN, mem_Dest, id_src2);
    if (fwd_en) begin
      // With forwarding only a load in EX cannot be bypassed in time.
      hazard_s = exe_MEM_R_EN & (hit_exe1_s | hit_exe2_s);
    end else begin
      hazard_s = hit_exe1_s | hit_exe2_s | hit_mem1_s | hit_mem2_s;
    end
  end

  // Forwarding select for the EX operands; MEM is younger so it wins over WB.
  always_comb begin
    sel1_s = SEL_RF;
    sel2_s = SEL_RF;
    if (fwd_en) begin
      if (reg_hit(mem_WB_EN, mem_Dest, exe_src1)) begin
        sel1_s = SEL_MEM;
      end else if (reg_hit(wb_WB_EN, wb_Dest, exe_src1)) begin
        sel1_s = SEL_WB;
      end else begin
        sel1_s = SEL_RF;
      end
      if (reg_hit(mem_WB_EN, mem_Dest, exe_src2)) begin
        sel2_s = SEL_MEM;
      end else if (reg_hit(wb_WB_EN, wb_Dest, exe_src2)) begin
        sel2_s = SEL_WB;
      end else begin
        sel2_s = SEL_RF;
      end
    end else begin
      sel1_s = SEL_RF;
      sel2_s = SEL_RF;
    end
  end

  // Memory-stall FSM next state, wait counter and stall request.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    err_set_s      = 1'b0;
    stall_s        = 1'b0;
    wait_inc_s     = {1'b0, wait_cnt_r} + 9'd1;
    case (state_r)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stall_s        = 1'b1;
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          stall_s = 1'b1;
          if (wait_inc_s >= WAIT_LAST) begin
            // Give up on the access: flag it and let the pipeline move again.
            err_set_s      = 1'b1;
            state_nxt_s    = RUN;
            wait_cnt_nxt_s = 8'd0;
          end else begin
            wait_cnt_nxt_s = wait_inc_s[7:0];
          end
        end
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Pipeline control: memory stall dominates, then branch, then hazard bubble.
  always_comb begin
    freeze_s = stall_s | (hazard_s & ~exe_B);
    flush_s  = ~stall_s & (exe_B | hazard_s);
  end

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      wait_cnt_r <= 8'd0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_r | err_set_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (freeze_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_s && exe_B) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  // Output drive; during reset the pipeline is held flushed and unstalled.
  always_comb begin
    freeze     = 1'b0;
    flush      = 1'b1;
    freeze_all = 1'b0;
    sel_src1   = SEL_RF;
    sel_src2   = SEL_RF;
    if (rst_n) begin
      freeze     = freeze_s;
      flush      = flush_s;
      freeze_all = stall_s;
      sel_src1   = sel1_s;
      sel_src2   = sel2_s;
    end else begin
      freeze     = 1'b0;
      flush      = 1'b1;
      freeze_all = 1'b0;
      sel_src1   = SEL_RF;
      sel_src2   = SEL_RF;
    end
  end

  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Scoreboard bench for hazard_fwd_ctrl: each cycle the expected outputs are
// computed from a reference model when the stimulus is driven, queued, and
// compared against the DUT on the falling edge. Directed scenarios are backed
// by hand-written constant checks. Counters use CNT_W=4 so saturation is hit.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_Dest, mem_Dest, wb_Dest;
  logic id_two_src, fwd_en, exe_WB_EN, exe_MEM_R_EN, exe_B;
  logic mem_WB_EN, mem_req, mem_ready, wb_WB_EN;
  logic freeze, flush, freeze_all, mem_err;
  logic [1:0] sel_src1, sel_src2;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_fwd_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .fwd_en(fwd_en),
    .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_Dest(exe_Dest),
    .exe_WB_EN(exe_WB_EN), .exe_MEM_R_EN(exe_MEM_R_EN), .exe_B(exe_B),
    .mem_Dest(mem_Dest), .mem_WB_EN(mem_WB_EN), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_Dest(wb_Dest), .wb_WB_EN(wb_WB_EN),
    .freeze(freeze), .flush(flush), .freeze_all(freeze_all),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct packed {
    logic             freeze;
    logic             flush;
    logic             freeze_all;
    logic [1:0]       sel1;
    logic [1:0]       sel2;
    logic             err;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flushes;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic m_wait;
  int   m_cnt;
  logic m_err;
  int   m_stall;
  int   m_flush;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  function automatic logic [1:0] fwd_sel(input logic [3:0] src);
    if (!fwd_en) return 2'b00;
    if (mem_WB_EN && mem_Dest == src) return 2'b01;
    if (wb_WB_EN && wb_Dest == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic e1, e2, m1, m2, haz, stall;
    e1 = exe_WB_EN && (exe_Dest == id_src1);
    e2 = id_two_src && exe_WB_EN && (exe_Dest == id_src2);
    m1 = mem_WB_EN && (mem_Dest == id_src1);
    m2 = id_two_src && mem_WB_EN && (mem_Dest == id_src2);
    haz = fwd_en ? (exe_MEM_R_EN && (e1 || e2)) : (e1 || e2 || m1 || m2);
    stall = m_wait ? !mem_ready : (mem_req && !mem_ready);
    e.freeze_all = stall;
    e.freeze     = stall || (haz && !exe_B);
    e.flush      = !stall && (exe_B || haz);
    e.sel1       = fwd_sel(exe_src1);
    e.sel2       = fwd_sel(exe_src2);
    e.err        = m_err;
    e.stall      = CNT_W'(m_stall);
    e.flushes    = CNT_W'(m_flush);
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    if (e.freeze && m_stall < MAXC) m_stall++;
    if (e.flush && exe_B && m_flush < MAXC) m_flush++;
    if (!m_wait) begin
      if (mem_req && !mem_ready) begin
        m_wait = 1'b1;
        m_cnt  = 0;
      end
    end else if (mem_ready) begin
      m_wait = 1'b0;
    end else if (m_cnt + 1 == TIMEOUT - 1) begin
      m_err  = 1'b1;
      m_wait = 1'b0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic clear_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; fwd_en = 1'b0;
    exe_src1 = 4'd0; exe_src2 = 4'd0; exe_Dest = 4'd0;
    exe_WB_EN = 1'b0; exe_MEM_R_EN = 1'b0; exe_B = 1'b0;
    mem_Dest = 4'd0; mem_WB_EN = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    wb_Dest = 4'd0; wb_WB_EN = 1'b0;
  endtask

  // One clock cycle: push expectation, compare on the falling edge, advance model.
  task automatic tick(input string tag);
    exp_t e;
    sb_q.push_back(model_out());
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq({tag, ".freeze"},     16'(freeze),       16'(e.freeze));
    check_eq({tag, ".flush"},      16'(flush),        16'(e.flush));
    check_eq({tag, ".freeze_all"}, 16'(freeze_all),   16'(e.freeze_all));
    check_eq({tag, ".sel_src1"},   16'(sel_src1),     16'(e.sel1));
    check_eq({tag, ".sel_src2"},   16'(sel_src2),     16'(e.sel2));
    check_eq({tag, ".mem_err"},    16'(mem_err),      16'(e.err));
    check_eq({tag, ".stall_cyc"},  16'(stall_cycles), 16'(e.stall));
    check_eq({tag, ".flush_cnt"},  16'(flush_count),  16'(e.flushes));
    @(posedge clk);
    model_step(e);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    // Inputs that would otherwise cause hazard, stall and forwarding.
    exe_WB_EN = 1'b1; exe_Dest = 4'd1; id_src1 = 4'd1; exe_B = 1'b1;
    mem_req = 1'b1; fwd_en = 1'b1; mem_WB_EN = 1'b1; mem_Dest = 4'd7; exe_src1 = 4'd7;
    #12;
    check_eq("rst.freeze",     16'(freeze),       16'd0);
    check_eq("rst.flush",      16'(flush),        16'd1);
    check_eq("rst.freeze_all", 16'(freeze_all),   16'd0);
    check_eq("rst.sel_src1",   16'(sel_src1),     16'd0);
    check_eq("rst.mem_err",    16'(mem_err),      16'd0);
    check_eq("rst.stall_cyc",  16'(stall_cycles), 16'd0);
    check_eq("rst.flush_cnt",  16'(flush_count),  16'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tick("idle");

    // Load-use with forwarding on
    fwd_en = 1'b1; exe_MEM_R_EN = 1'b1; exe_WB_EN = 1'b1; exe_Dest = 4'd3; id_src1 = 4'd3;
    #1;
    check_eq("lu.freeze", 16'(freeze), 16'd1);
    check_eq("lu.flush",  16'(flush),  16'd1);
    tick("load_use");
    clear_inputs();
    tick("after_lu");
    check_eq("lu.stall_cyc", 16'(stall_cycles), 16'd1);

    // Forwarding priority MEM over WB
    fwd_en = 1'b1; exe_src1 = 4'd5; mem_WB_EN = 1'b1; mem_Dest = 4'd5;
    wb_WB_EN = 1'b1; wb_Dest = 4'd5; exe_src2 = 4'd5;
    #1;
    check_eq("fwd.mem", 16'(sel_src1), 16'd1);
    tick("fwd_mem");
    mem_Dest = 4'd6;
    #1;
    check_eq("fwd.wb", 16'(sel_src1), 16'd2);
    tick("fwd_wb");
    // Forwardable EX dependency (not a load) causes no stall
    exe_WB_EN = 1'b1; exe_Dest = 4'd9; id_src1 = 4'd9;
    tick("fwd_no_lu");

    // No forwarding: MEM dependency on src2
    clear_inputs();
    mem_WB_EN = 1'b1; mem_Dest = 4'd2; id_two_src = 1'b1; id_src2 = 4'd2;
    wb_WB_EN = 1'b1; wb_Dest = 4'd0;
    #1;
    check_eq("nofwd.freeze", 16'(freeze),   16'd1);
    check_eq("nofwd.flush",  16'(flush),    16'd1);
    check_eq("nofwd.sel2",   16'(sel_src2), 16'd0);
    tick("no_fwd");
    id_two_src = 1'b0;
    tick("no_two_src");

    // Branch under memory stall
    clear_inputs();
    mem_req = 1'b1; exe_B = 1'b1;
    #1;
    check_eq("brst.flush", 16'(flush), 16'd0);
    repeat (3) tick("br_stall");
    mem_ready = 1'b1;
    #1;
    check_eq("brst.release_flush", 16'(flush), 16'd1);
    tick("br_release");
    check_eq("brst.flush_cnt", 16'(flush_count), 16'd1);
    clear_inputs();
    tick("br_idle");

    // Branch and hazard together: branch wins
    exe_B = 1'b1; exe_WB_EN = 1'b1; exe_Dest = 4'd4; id_src1 = 4'd4;
    #1;
    check_eq("brhz.freeze", 16'(freeze), 16'd0);
    check_eq("brhz.flush",  16'(flush),  16'd1);
    tick("br_hazard");

    // Memory wait of four cycles
    clear_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("mw.freeze_all", 16'(freeze_all), 16'd1);
      tick("mem_wait");
    end
    mem_ready = 1'b1;
    tick("mem_done");
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    check_eq("mw.back_in_run", 16'(freeze_all), 16'd0);
    check_eq("mw.no_err",      16'(mem_err),    16'd0);
    tick("mem_idle");

    // Random traffic on a narrow register range
    for (int i = 0; i < 60; i++) begin
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      id_two_src = 1'($urandom); fwd_en = 1'($urandom);
      exe_src1 = 4'($urandom_range(0, 3)); exe_src2 = 4'($urandom_range(0, 3));
      exe_Dest = 4'($urandom_range(0, 3)); exe_WB_EN = 1'($urandom);
      exe_MEM_R_EN = 1'($urandom); exe_B = ($urandom_range(0, 3) == 0);
      mem_Dest = 4'($urandom_range(0, 3)); mem_WB_EN = 1'($urandom);
      mem_req = ($urandom_range(0, 3) == 0); mem_ready = ($urandom_range(0, 2) != 0);
      wb_Dest = 4'($urandom_range(0, 3)); wb_WB_EN = 1'($urandom);
      tick("random");
    end
    clear_inputs();
    mem_ready = 1'b1;
    repeat (2) tick("drain");

    // Timeout: TIMEOUT consecutive stalled cycles raise mem_err
    clear_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == TIMEOUT - 1) check_eq("to.err_not_yet", 16'(mem_err), 16'd0);
      tick("timeout");
    end
    mem_req = 1'b0;
    #1;
    check_eq("to.mem_err",    16'(mem_err),      16'd1);
    check_eq("to.run",        16'(freeze_all),   16'd0);
    check_eq("to.stall_sat",  16'(stall_cycles), 16'(MAXC));
    tick("after_timeout");

    // Reset in the middle of a memory wait
    mem_req = 1'b1;
    repeat (3) tick("pre_reset_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst.mem_err",    16'(mem_err),      16'd0);
    check_eq("mrst.stall_cyc",  16'(stall_cycles), 16'd0);
    check_eq("mrst.flush_cnt",  16'(flush_count),  16'd0);
    check_eq("mrst.freeze_all", 16'(freeze_all),   16'd0);
    check_eq("mrst.flush",      16'(flush),        16'd1);
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick("post_reset_idle");
    mem_req = 1'b1;
    tick("post_reset_stall");
    mem_ready = 1'b1;
    tick("post_reset_done");
    clear_inputs();
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: MEM_WAIT cycles before mem_err is raised.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have inputs id_src1, id_src2 (4 each): source registers of the instruction in ID.
REQ-006 SHALL have input id_two_src (1): the ID instruction reads id_src2.
REQ-007 SHALL have input fwd_en (1): forwarding enabled.
REQ-008 SHALL have inputs exe_src1, exe_src2 (4 each): scr1_out/scr2_out of the ID/EX register.
REQ-009 SHALL have inputs exe_Dest (4), exe_WB_EN, exe_MEM_R_EN, exe_B (1 each): ID/EX outputs.
REQ-010 SHALL have inputs mem_Dest (4), mem_WB_EN, mem_req, mem_ready (1 each): MEM-stage status; mem_req means a load or store is in MEM.
REQ-011 SHALL have inputs wb_Dest (4), wb_WB_EN (1): WB-stage status.
REQ-012 SHALL have outputs freeze (1): hold PC and IF/ID; flush (1): ID/EX and IF/ID flush; freeze_all (1): hold every pipeline register.
REQ-013 SHALL have outputs sel_src1, sel_src2 (2 each): 00 register file, 01 MEM result, 10 WB result.
REQ-014 SHALL have outputs mem_err (1, sticky), stall_cycles (CNT_W), flush_count (CNT_W).

Function
REQ-015 SHALL compute hit_exe1 as exe_WB_EN & (exe_Dest==id_src1), and hit_exe2 as id_two_src & exe_WB_EN & (exe_Dest==id_src2); SHALL compute hit_mem1 and hit_mem2 the same way using mem_Dest and mem_WB_EN.
REQ-016 SHALL, with fwd_en=0, set hazard = hit_exe1|hit_exe2|hit_mem1|hit_mem2.
REQ-017 SHALL, with fwd_en=1, set hazard = exe_MEM_R_EN & (hit_exe1|hit_exe2), i.e. load-use only.
REQ-018 SHALL, with fwd_en=1, drive sel_src1 combinationally: 01 if mem_WB_EN & mem_Dest==exe_src1, else 10 if wb_WB_EN & wb_Dest==exe_src1, else 00 (MEM has priority over WB); sel_src2 the same using exe_src2.
REQ-019 SHALL drive sel_src1 and sel_src2 as 00 whenever fwd_en=0.
REQ-020 SHALL implement FSM states RUN and MEM_WAIT, with state and an 8-bit wait counter as the only control state.
REQ-021 SHALL transition RUN->MEM_WAIT when mem_req=1 and mem_ready=0, clearing the wait counter.
REQ-022 SHALL remain in MEM_WAIT while mem_ready=0, incrementing the wait counter each cycle.
REQ-023 SHALL transition MEM_WAIT->RUN on mem_ready=1.
REQ-024 SHALL, on a MEM_WAIT cycle where the wait counter reaches TIMEOUT-1 with mem_ready=0, set mem_err (held until reset) and force MEM_WAIT->RUN.
REQ-025 SHALL drive freeze_all = 1 combinationally while in RUN with mem_req=1 and mem_ready=0, and while in MEM_WAIT with mem_ready=0.
REQ-026 SHALL drive freeze = freeze_all | (hazard & ~exe_B).
REQ-027 SHALL drive flush = ~freeze_all & (exe_B | hazard): a branch flushes; a hazard inserts a bubble into ID/EX.
REQ-028 SHALL give exe_B priority over hazard: on a simultaneous branch and hazard, flush=1 and freeze=0, because the dependent instruction is discarded.
REQ-029 SHALL give freeze_all priority over everything: flush=0 during a memory stall even if exe_B=1, and the branch is acted on in the first non-stalled cycle.
REQ-030 SHALL increment stall_cycles on each cycle with freeze=1, saturating at all-ones.
REQ-031 SHALL increment flush_count on each cycle with flush=1 & exe_B, saturating at all-ones.
REQ-032 SHALL keep hazard detection, forwarding and output logic combinational (zero latency); only the FSM, wait counter, mem_err and the two performance counters are registered.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force state=RUN, wait counter=0, mem_err=0, stall_cycles=0, flush_count=0.
REQ-034 SHALL, while rst_n=0, force outputs freeze=0, freeze_all=0, flush=1 and sel_src1=sel_src2=00, independent of the other inputs.
REQ-035 SHALL, on reset asserted mid-MEM_WAIT, abandon the wait with no mem_err and resume in RUN on the first edge after rst_n rises.

Verification
REQ-036 Load-use: fwd_en=1, exe_MEM_R_EN=1, exe_WB_EN=1, exe_Dest=3, id_src1=3 -> freeze=1 and flush=1 for one cycle; stall_cycles +1.
REQ-037 Forwarding: exe_src1=5, mem_WB_EN=1, mem_Dest=5, wb_WB_EN=1, wb_Dest=5 -> sel_src1=01; change mem_Dest to 6 -> sel_src1=10.
REQ-038 No forwarding: fwd_en=0, mem_WB_EN=1, mem_Dest=2, id_two_src=1, id_src2=2 -> freeze=1, flush=1, sel_src2=00.
REQ-039 Memory wait: mem_req=1, mem_ready held 0 for 4 cycles then 1 -> freeze_all=1 for 4 cycles, state back to RUN, mem_err=0.
REQ-040 Branch under stall: exe_B=1 during MEM_WAIT -> flush=0; after mem_ready=1 -> flush=1 and flush_count=1.
REQ-041 Timeout and reset: mem_ready held 0 for 16 cycles -> mem_err=1 and state RUN; then pull rst_n low mid-cycle -> mem_err=0 and counters=0 immediately.
